fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_if.sv | 24 ++
 rtl/fetch_queue.sv | 109 ++++++++++
 tb/tb_fetch_queue.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch queue, instruction memory and the datapath.
// The master side is the fetch queue itself; the slave side is its environment.
interface fetch_queue_if;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck;
    logic [31:0] memData;
    logic        instValid;
    logic [31:0] instPc;
    logic [31:0] instruction;
    logic        instReady;

    modport master (
        input  redirectValid, redirectPc, memAck, memData, instReady,
        output memReq, memAddr, instValid, instPc, instruction
    );

    modport slave (
        output redirectValid, redirectPc, memAck, memData, instReady,
        input  memReq, memAddr, instValid, instPc, instruction
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one outstanding memory request, a DEPTH-entry {pc, instruction}
// FIFO, and a DROP state that swallows the in-flight response after a redirect.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clock,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam int unsigned PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W     = PW + 1;
    localparam logic [PW-1:0]    PTR_ONE   = PW'(1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] DROP  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic             mem_req_q, mem_req_d;

    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] inst_mem [DEPTH];

    logic        handshake;
    logic        hold;
    logic        push;
    logic        pop;
    logic [31:0] target;

    always_comb begin
        handshake = mem_req_q & bus.memAck;
        hold      = mem_req_q & ~bus.memAck;
        push      = (state_q == FETCH) & handshake & ~bus.redirectValid;
        pop       = (count_q != '0) & bus.instReady & ~bus.redirectValid;
        target    = bus.redirectPc & ~32'h3;

        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;

        if (bus.redirectValid) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = target;
        end else begin
            if (push) begin
                tail_d     = tail_q + PTR_ONE;
                fetch_pc_d = mem_addr_q + 32'd4;
            end
            if (pop) begin
                head_d = head_q + PTR_ONE;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        // A redirect that lands while a request is still in flight must wait for that
        // response to drain; any completed or absent request frees us to fetch again.
        if (hold) begin
            state_d    = bus.redirectValid ? DROP : state_q;
            mem_req_d  = 1'b1;
            mem_addr_d = mem_addr_q;
        end else begin
            state_d    = FETCH;
            mem_req_d  = (count_d < DEPTH_CNT);
            mem_addr_d = fetch_pc_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= FETCH;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= RESET_PC;
            mem_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && push) begin
            pc_mem[tail_q]   <= mem_addr_q;
            inst_mem[tail_q] <= bus.memData;
        end
    end

    assign bus.memReq      = mem_req_q;
    assign bus.memAddr     = mem_addr_q;
    assign bus.instValid   = (count_q != '0);
    assign bus.instPc      = (count_q != '0) ? pc_mem[head_q] : 32'h0;
    assign bus.instruction = (count_q != '0) ? inst_mem[head_q] : 32'h0;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_fetch_queue;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic        rst_n;
        logic        rv;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] data;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        chk_addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic clock = 1'b0;
    logic reset;
    logic reset_w;
    always #5 clock = ~clock;

    fetch_queue_if bus ();
    fetch_queue_if bus_w ();

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clock (clock),
        .reset (reset_w),
        .bus   (bus_w.master)
    );

    int tests = 0;
    int fails = 0;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic rst_n, input logic rv, input logic [31:0] rpc,
                         input logic ack, input logic [31:0] data, input logic rdy);
        reset             = rst_n;
        bus.redirectValid = rv;
        bus.redirectPc    = rpc;
        bus.memAck        = ack;
        bus.memData       = data;
        bus.instReady     = rdy;
        tick();
    endtask

    task automatic expect_out(input string name, input logic req, input logic [31:0] addr,
                              input logic chk_addr, input logic valid, input logic [31:0] pc,
                              input logic [31:0] inst);
        chk({name, ".memReq"}, {31'b0, bus.memReq}, {31'b0, req});
        if (chk_addr) chk({name, ".memAddr"}, bus.memAddr, addr);
        chk({name, ".instValid"}, {31'b0, bus.instValid}, {31'b0, valid});
        chk({name, ".instPc"}, bus.instPc, pc);
        chk({name, ".instruction"}, bus.instruction, inst);
    endtask

    function automatic vec_t mk(logic rst_n, logic rv, logic [31:0] rpc, logic ack,
                                logic [31:0] data, logic rdy, logic req, logic [31:0] addr,
                                logic chk_addr, logic valid, logic [31:0] pc, logic [31:0] inst);
        vec_t v;
        v = '{rst_n, rv, rpc, ack, data, rdy, req, addr, chk_addr, valid, pc, inst};
        return v;
    endfunction

    // Reference model state: spec-level view of the queue and the single request slot.
    ent_t        mq[$];
    logic [31:0] m_pc, m_addr;
    logic        m_req, m_drop;

    task automatic model_step(input logic rst_n, input logic rv, input logic [31:0] rpc,
                              input logic ack, input logic [31:0] data, input logic rdy);
        logic hs, waiting, popv;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
            m_pc = 32'h0; m_addr = 32'h0; m_req = 1'b0; m_drop = 1'b0;
            return;
        end
        hs      = m_req && ack;
        waiting = m_req && !ack;
        if (rv) begin
            mq.delete();
            m_pc = {rpc[31:2], 2'b00};
            if (waiting) m_drop = 1'b1;
            else begin m_drop = 1'b0; m_req = 1'b1; m_addr = m_pc; end
        end else begin
            popv = (mq.size() != 0) && rdy;
            if (popv) void'(mq.pop_front());
            if (hs) begin
                if (!m_drop) begin
                    e.pc = m_addr; e.inst = data;
                    mq.push_back(e);
                    m_pc = m_addr + 32'd4;
                end
                m_drop = 1'b0;
            end
            if (!waiting) begin
                m_req  = (mq.size() < DEPTH);
                m_addr = m_pc;
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        reset_w = 1'b0;
        bus.redirectValid = 1'b0; bus.redirectPc = '0; bus.memAck = 1'b0;
        bus.memData = '0; bus.instReady = 1'b0;
        bus_w.redirectValid = 1'b0; bus_w.redirectPc = '0; bus_w.memAck = 1'b0;
        bus_w.memData = '0; bus_w.instReady = 1'b0;

        // rst_n rv rpc ack data rdy | req addr chk_addr valid pc inst
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,  1, 0, 32'h0,  32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 32'hDEAD_BEEF, 1, 0, 32'h0,  1, 0, 32'h0,  32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,         1, 1, 32'h0,  1, 0, 32'h0,  32'h0));
        vecs.push_back(mk(1, 0, 0, 1, 32'hA000_0000, 1, 1, 32'h4,  1, 1, 32'h0,  32'hA000_0000));
        vecs.push_back(mk(1, 0, 0, 1, 32'hA000_0001, 1, 1, 32'h8,  1, 1, 32'h4,  32'hA000_0001));
        vecs.push_back(mk(1, 0, 0, 1, 32'hA000_0002, 1, 1, 32'hC,  1, 1, 32'h8,  32'hA000_0002));
        vecs.push_back(mk(1, 0, 0, 1, 32'hA000_0003, 1, 1, 32'h10, 1, 1, 32'hC,  32'hA000_0003));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,  1, 0, 32'h0,  32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,         0, 1, 32'h0,  1, 0, 32'h0,  32'h0));
        vecs.push_back(mk(1, 0, 0, 1, 32'hB000_0000, 0, 1, 32'h4,  1, 1, 32'h0,  32'hB000_0000));
        vecs.push_back(mk(1, 0, 0, 1, 32'hB000_0001, 0, 1, 32'h8,  1, 1, 32'h0,  32'hB000_0000));
        vecs.push_back(mk(1, 0, 0, 1, 32'hB000_0002, 0, 1, 32'hC,  1, 1, 32'h0,  32'hB000_0000));
        vecs.push_back(mk(1, 0, 0, 1, 32'hB000_0003, 0, 0, 32'h0,  0, 1, 32'h0,  32'hB000_0000));
        vecs.push_back(mk(1, 0, 0, 1, 32'hB000_0099, 0, 0, 32'h0,  0, 1, 32'h0,  32'hB000_0000));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,         1, 1, 32'h10, 1, 1, 32'h4,  32'hB000_0001));
        vecs.push_back(mk(1, 0, 0, 1, 32'hB000_0004, 0, 0, 32'h0,  0, 1, 32'h4,  32'hB000_0001));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,         1, 1, 32'h14, 1, 1, 32'h8,  32'hB000_0002));

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].rv, vecs[i].rpc, vecs[i].ack, vecs[i].data, vecs[i].rdy);
            expect_out($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].chk_addr,
                       vecs[i].valid, vecs[i].pc, vecs[i].inst);
        end

        // Redirect while request 8 is pending; its late response must be dropped.
        drive(0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 1, 32'hC000_0000, 1);
        drive(1, 0, 0, 1, 32'hC000_0004, 1);
        expect_out("pend.before", 1, 32'h8, 1, 1, 32'h4, 32'hC000_0004);
        drive(1, 1, 32'h103, 0, 0, 1);
        expect_out("pend.redirect", 1, 32'h8, 1, 0, 32'h0, 32'h0);
        drive(1, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 1);
        expect_out("pend.hold", 1, 32'h8, 1, 0, 32'h0, 32'h0);
        drive(1, 0, 0, 1, 32'hBAD0_0008, 1);
        expect_out("pend.drop", 1, 32'h100, 1, 0, 32'h0, 32'h0);
        drive(1, 0, 0, 1, 32'hC000_0100, 0);
        expect_out("pend.first", 1, 32'h104, 1, 1, 32'h100, 32'hC000_0100);

        // Redirect coinciding with a push and a pop.
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 32'hD000_0000, 0);
        drive(1, 1, 32'h40, 1, 32'hD000_0004, 1);
        expect_out("simul.flush", 1, 32'h40, 1, 0, 32'h0, 32'h0);
        drive(1, 0, 0, 0, 0, 1);
        expect_out("simul.next", 1, 32'h40, 1, 0, 32'h0, 32'h0);

        // Reset mid-operation with three entries queued and a request pending.
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 32'hE000_0000, 0);
        drive(1, 0, 0, 1, 32'hE000_0004, 0);
        drive(1, 0, 0, 1, 32'hE000_0008, 0);
        expect_out("midrst.before", 1, 32'hC, 1, 1, 32'h0, 32'hE000_0000);
        drive(0, 0, 0, 1, 32'hE000_000C, 1);
        expect_out("midrst.reset", 0, 32'h0, 1, 0, 32'h0, 32'h0);
        drive(1, 0, 0, 0, 0, 0);
        expect_out("midrst.release", 1, 32'h0, 1, 0, 32'h0, 32'h0);

        // Address wrap-around on the second instance.
        tick();
        reset_w = 1'b1;
        tick();
        chk("wrap.req0", {31'b0, bus_w.memReq}, 32'h1);
        chk("wrap.addr0", bus_w.memAddr, 32'hFFFF_FFF8);
        bus_w.memAck = 1'b1; bus_w.instReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_w.memData = 32'hF000_0000 + 32'(i);
            tick();
            chk($sformatf("wrap.pc%0d", i), bus_w.instPc, 32'hFFFF_FFF8 + 32'(4 * i));
            chk($sformatf("wrap.inst%0d", i), bus_w.instruction, 32'hF000_0000 + 32'(i));
        end
        chk("wrap.addr3", bus_w.memAddr, 32'h4);
        bus_w.memAck = 1'b0;

        // Randomized run against the reference model.
        for (int i = 0; i < 1500; i++) begin
            logic rst_n, rv, ack, rdy;
            logic [31:0] rpc, data;
            rst_n = (i == 0) ? 1'b0 : ($urandom_range(0, 79) != 0);
            rv    = ($urandom_range(0, 11) == 0);
            rpc   = $urandom;
            ack   = ($urandom_range(0, 2) != 0);
            data  = $urandom;
            rdy   = ($urandom_range(0, 3) != 0) && (i % 97 > 20);
            model_step(rst_n, rv, rpc, ack, data, rdy);
            drive(rst_n, rv, rpc, ack, data, rdy);
            expect_out($sformatf("rand%0d", i), m_req, m_addr, m_req || !rst_n,
                       mq.size() != 0,
                       (mq.size() != 0) ? mq[0].pc : 32'h0,
                       (mq.size() != 0) ? mq[0].inst : 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
